// File: rtl/htu_req_queue_if.sv
// Request-queue bus bundle: crossbar-side request handshake plus the
// hit-test-unit-side head-entry handshake and the occupancy count.
// slave  = the queue itself, master = the requester/consumer environment.
interface htu_req_queue_if #(
  parameter int CNT_W = 3
);

  // crossbar -> queue
  logic             xbar_htu_valid_i;
  logic             xbar_htu_ready_o;
  logic [1:0]       xbar_htu_ch_id_i;
  logic [1:0]       xbar_htu_opcode_i;
  logic [27:0]      xbar_htu_addr_i;
  logic [7:0]       xbar_htu_wbuffer_id_i;

  // queue -> hit-test unit
  logic             htu_req_valid_o;
  logic             htu_req_ready_i;
  logic [1:0]       htu_req_ch_id_o;
  logic [1:0]       htu_req_opcode_o;
  logic [27:0]      htu_req_addr_o;
  logic [7:0]       htu_req_wbuffer_id_o;

  // occupancy
  logic [CNT_W-1:0] htu_req_cnt_o;

  modport slave (
    input  xbar_htu_valid_i,
    input  xbar_htu_ch_id_i,
    input  xbar_htu_opcode_i,
    input  xbar_htu_addr_i,
    input  xbar_htu_wbuffer_id_i,
    input  htu_req_ready_i,
    output xbar_htu_ready_o,
    output htu_req_valid_o,
    output htu_req_ch_id_o,
    output htu_req_opcode_o,
    output htu_req_addr_o,
    output htu_req_wbuffer_id_o,
    output htu_req_cnt_o
  );

  modport master (
    output xbar_htu_valid_i,
    output xbar_htu_ch_id_i,
    output xbar_htu_opcode_i,
    output xbar_htu_addr_i,
    output xbar_htu_wbuffer_id_i,
    output htu_req_ready_i,
    input  xbar_htu_ready_o,
    input  htu_req_valid_o,
    input  htu_req_ch_id_o,
    input  htu_req_opcode_o,
    input  htu_req_addr_o,
    input  htu_req_wbuffer_id_o,
    input  htu_req_cnt_o
  );

endinterface

// File: rtl/htu_req_queue.sv
// htu_req_queue: DEPTH-entry circular FIFO that buffers crossbar requests
// in front of the hit-test unit. Each entry is {ch_id, opcode, addr, wbuffer_id}.
// Optional feature: define HTU_REQQ_BYPASS_EN to let a request arriving at an
// empty queue pass straight through to the hit-test unit in the same cycle.
// Without it the head is always taken from storage (one cycle minimum latency).
module htu_req_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  htu_req_queue_if.slave  bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 40;

  // storage and bookkeeping
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_enq;
  logic               w_deq;
  logic               w_outValid;
  logic [ENTRY_W-1:0] w_inEntry;
  logic [ENTRY_W-1:0] w_headEntry;
  logic [ENTRY_W-1:0] w_outEntry;
  logic [PTR_W-1:0]   w_wrPtrNext;
  logic [PTR_W-1:0]   w_rdPtrNext;

  assign w_full      = (r_cnt == CNT_W'(DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_inEntry   = {bus.xbar_htu_ch_id_i, bus.xbar_htu_opcode_i,
                        bus.xbar_htu_addr_i, bus.xbar_htu_wbuffer_id_i};
  assign w_headEntry = r_mem[r_rdPtr];

  // Pointers wrap explicitly at DEPTH-1 so the intent does not hinge on
  // DEPTH being a power of two.
  assign w_wrPtrNext = (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
  assign w_rdPtrNext = (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);

`ifdef HTU_REQQ_BYPASS_EN
  logic w_bypass;
  logic w_bypassTaken;

  // An empty queue presents the incoming request directly; if the hit-test
  // unit takes it in that cycle it never touches storage.
  assign w_bypass      = w_empty & bus.xbar_htu_valid_i;
  assign w_bypassTaken = w_bypass & bus.htu_req_ready_i;
  assign w_outValid    = ~w_empty | bus.xbar_htu_valid_i;
  assign w_outEntry    = w_empty ? w_inEntry : w_headEntry;
  assign w_enq         = bus.xbar_htu_valid_i & ~w_full & ~w_bypassTaken;
  assign w_deq         = ~w_empty & bus.htu_req_ready_i;
`else
  // Output is purely a function of stored state: no input-to-output path.
  assign w_outValid    = ~w_empty;
  assign w_outEntry    = w_headEntry;
  assign w_enq         = bus.xbar_htu_valid_i & ~w_full;
  assign w_deq         = ~w_empty & bus.htu_req_ready_i;
`endif

  // Ready depends only on registered occupancy, so a full queue cannot
  // accept in the same cycle it drains; the slot opens the next cycle.
  assign bus.xbar_htu_ready_o     = ~w_full;
  assign bus.htu_req_valid_o      = w_outValid;
  assign bus.htu_req_ch_id_o      = w_outEntry[39:38];
  assign bus.htu_req_opcode_o     = w_outEntry[37:36];
  assign bus.htu_req_addr_o       = w_outEntry[35:8];
  assign bus.htu_req_wbuffer_id_o = w_outEntry[7:0];
  assign bus.htu_req_cnt_o        = r_cnt;

  // Entry storage is write-only on enqueue and never reset; stale contents
  // are unreachable because the pointers and count are cleared.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wrPtr] <= w_inEntry;
    end
  end

  // Write/read pointer advance on enqueue/dequeue respectively.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_enq) begin
        r_wrPtr <= w_wrPtrNext;
      end
      if (w_deq) begin
        r_rdPtr <= w_rdPtrNext;
      end
    end
  end

  // Occupancy moves only when exactly one of enqueue/dequeue happens.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else begin
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_htu_req_queue.sv
// Scoreboard bench for htu_req_queue: stimulus pushes the expected entry when
// the queue accepts it; an independent monitor pops and compares whenever the
// head is handed to the hit-test unit.
module tb_htu_req_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  int          total = 0;
  int          bad   = 0;
  logic [39:0] sb [$];
  bit          randDone = 1'b0;
  logic [39:0] vecs [12];

  htu_req_queue_if #(.CNT_W(CNT_W)) bus ();

  htu_req_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // free-running clock, period 10
  always #5 clk_i = ~clk_i;

  // one comparison: counts, and reports on mismatch
  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // drive one request at posedge+1 and hold it until the queue accepts it
  task automatic applyStimulus(input logic [39:0] req);
    bit done;
    done = 1'b0;
    bus.xbar_htu_valid_i      = 1'b1;
    bus.xbar_htu_ch_id_i      = req[39:38];
    bus.xbar_htu_opcode_i     = req[37:36];
    bus.xbar_htu_addr_i       = req[35:8];
    bus.xbar_htu_wbuffer_id_i = req[7:0];
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk_i);
      if (bus.xbar_htu_ready_o) begin
        sb.push_back(req);
        done = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end
    bus.xbar_htu_valid_i      = 1'b0;
    bus.xbar_htu_ch_id_i      = 2'($urandom);
    bus.xbar_htu_opcode_i     = 2'($urandom);
    bus.xbar_htu_addr_i       = 28'($urandom);
    bus.xbar_htu_wbuffer_id_i = 8'($urandom);
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout actual=not accepted required=accepted");
    end
  endtask

  // wait (bounded) for the queue and scoreboard to empty
  task automatic waitDrain();
    int k;
    k = 0;
    while ((sb.size() != 0 || bus.htu_req_cnt_o != '0) && k < 300) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    checkOutput("drain_sb_empty", 40'(sb.size()), 40'd0);
    checkOutput("drain_cnt", 40'(bus.htu_req_cnt_o), 40'd0);
  endtask

  // monitor: compare every head handoff against the scoreboard
  initial begin
    logic [39:0] exp;
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_i === 1'b1) begin
        checkOutput("cnt_le_depth", 40'(bus.htu_req_cnt_o <= CNT_W'(DEPTH)), 40'd1);
        if (bus.htu_req_valid_o && bus.htu_req_ready_i) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_output actual=0x%0h required=no pending entry",
                     {bus.htu_req_ch_id_o, bus.htu_req_opcode_o,
                      bus.htu_req_addr_o, bus.htu_req_wbuffer_id_o});
          end else begin
            exp = sb.pop_front();
            checkOutput("head_entry",
                        {bus.htu_req_ch_id_o, bus.htu_req_opcode_o,
                         bus.htu_req_addr_o, bus.htu_req_wbuffer_id_o}, exp);
          end
        end
      end
    end
  end

  // watchdog
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // main directed + random sequence
  initial begin
    vecs[0]  = {2'd1, 2'd2, 28'h1234567, 8'h5A};
    vecs[1]  = {2'd0, 2'd1, 28'h0000010, 8'h01};
    vecs[2]  = {2'd2, 2'd3, 28'hFFFFFFF, 8'hFF};
    vecs[3]  = {2'd1, 2'd0, 28'hA5A5A5A, 8'h3C};
    vecs[4]  = {2'd0, 2'd2, 28'h5A5A5A5, 8'hC3};
    vecs[5]  = {2'd2, 2'd1, 28'h0F0F0F0, 8'h80};
    vecs[6]  = {2'd1, 2'd3, 28'hDEADBEE, 8'h7E};
    vecs[7]  = {2'd0, 2'd0, 28'h0000000, 8'h00};
    vecs[8]  = {2'd2, 2'd2, 28'h8000001, 8'h42};
    vecs[9]  = {2'd1, 2'd1, 28'h1111111, 8'h11};
    vecs[10] = {2'd0, 2'd3, 28'h2222222, 8'h22};
    vecs[11] = {2'd2, 2'd0, 28'h3333333, 8'h33};

    bus.xbar_htu_valid_i      = 1'b0;
    bus.xbar_htu_ch_id_i      = '0;
    bus.xbar_htu_opcode_i     = '0;
    bus.xbar_htu_addr_i       = '0;
    bus.xbar_htu_wbuffer_id_i = '0;
    bus.htu_req_ready_i       = 1'b0;

    // reset state
    #2 rst_i = 1'b0;
    #1;
    checkOutput("reset_valid", 40'(bus.htu_req_valid_o), 40'd0);
    checkOutput("reset_cnt", 40'(bus.htu_req_cnt_o), 40'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("reset_ready", 40'(bus.xbar_htu_ready_o), 40'd1);
    @(posedge clk_i);
    #1;

    // single request with consumer ready
    $display("[TB] single request");
    bus.htu_req_ready_i = 1'b1;
    applyStimulus(vecs[0]);
`ifdef HTU_REQQ_BYPASS_EN
    checkOutput("single_cnt", 40'(bus.htu_req_cnt_o), 40'd0);
    checkOutput("single_valid_after", 40'(bus.htu_req_valid_o), 40'd0);
`else
    checkOutput("single_latency_valid", 40'(bus.htu_req_valid_o), 40'd1);
    checkOutput("single_latency_cnt", 40'(bus.htu_req_cnt_o), 40'd1);
    @(posedge clk_i);
    #1;
    checkOutput("single_cnt", 40'(bus.htu_req_cnt_o), 40'd0);
    checkOutput("single_valid_after", 40'(bus.htu_req_valid_o), 40'd0);
`endif
    waitDrain();

    // fill to full with consumer stalled, then a fifth waits for space
    $display("[TB] fill and backpressure");
    bus.htu_req_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) applyStimulus(vecs[i]);
    fork
      applyStimulus(vecs[5]);
      begin
        @(negedge clk_i);
        checkOutput("full_cnt", 40'(bus.htu_req_cnt_o), 40'd4);
        checkOutput("full_ready", 40'(bus.xbar_htu_ready_o), 40'd0);
        checkOutput("full_valid", 40'(bus.htu_req_valid_o), 40'd1);
        @(posedge clk_i);
        #1 bus.htu_req_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("full_deq_ready_same", 40'(bus.xbar_htu_ready_o), 40'd0);
        checkOutput("full_deq_cnt_same", 40'(bus.htu_req_cnt_o), 40'd4);
        @(negedge clk_i);
        checkOutput("full_deq_ready_next", 40'(bus.xbar_htu_ready_o), 40'd1);
        checkOutput("full_deq_cnt_next", 40'(bus.htu_req_cnt_o), 40'd3);
        @(posedge clk_i);
        #1;
      end
    join
    waitDrain();

    // steady occupancy 2 with simultaneous enqueue/dequeue across wrap
    $display("[TB] steady occupancy");
    bus.htu_req_ready_i = 1'b0;
    applyStimulus(vecs[6]);
    applyStimulus(vecs[7]);
    checkOutput("steady_start_cnt", 40'(bus.htu_req_cnt_o), 40'd2);
    bus.htu_req_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[(i % 4) + 8 - ((i % 4) == 3 ? 0 : 0)]);
      checkOutput("steady_cnt", 40'(bus.htu_req_cnt_o), 40'd2);
    end
    waitDrain();

    // reset in the middle of a stream discards queued entries
    $display("[TB] mid-stream reset");
    bus.htu_req_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) applyStimulus(vecs[i]);
    checkOutput("prereset_cnt", 40'(bus.htu_req_cnt_o), 40'd3);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("midreset_valid", 40'(bus.htu_req_valid_o), 40'd0);
    checkOutput("midreset_cnt", 40'(bus.htu_req_cnt_o), 40'd0);
    sb.delete();
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("postreset_ready", 40'(bus.xbar_htu_ready_o), 40'd1);
    checkOutput("postreset_valid", 40'(bus.htu_req_valid_o), 40'd0);
    @(posedge clk_i);
    #1;
    bus.htu_req_ready_i = 1'b1;
    applyStimulus(vecs[11]);
    waitDrain();

    // random valid/ready traffic
    $display("[TB] random traffic");
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [39:0] r;
          while ($urandom_range(0, 1) == 1) begin
            @(posedge clk_i);
            #1;
          end
          r = {2'($urandom_range(0, 2)), 2'($urandom), 28'($urandom), 8'($urandom)};
          applyStimulus(r);
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk_i);
          #1 bus.htu_req_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.htu_req_ready_i = 1'b1;
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/htu_req_queue.md
HTU_REQ_QUEUE -- requirements
Module: htu_req_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 3, occupancy counter width; must equal log2(DEPTH)+1.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port xbar_htu_valid_i  input  1  crossbar request valid.
REQ-006 SHALL have port xbar_htu_ready_o  output  1  queue can accept a request.
REQ-007 SHALL have port xbar_htu_ch_id_i  input  2  source channel 0..2.
REQ-008 SHALL have port xbar_htu_opcode_i  input  2  request opcode.
REQ-009 SHALL have port xbar_htu_addr_i  input  28  line address [31:4].
REQ-010 SHALL have port xbar_htu_wbuffer_id_i  input  8  write-buffer slot id.
REQ-011 SHALL have port htu_req_valid_o  output  1  head entry valid toward hit-test unit.
REQ-012 SHALL have port htu_req_ready_i  input  1  hit-test unit accepts head.
REQ-013 SHALL have ports htu_req_ch_id_o (2), htu_req_opcode_o (2), htu_req_addr_o (28), htu_req_wbuffer_id_o (8)  output  head entry fields.
REQ-014 SHALL have port htu_req_cnt_o  output  CNT_W  current occupancy.

Function
REQ-015 SHALL store each accepted request as one 40-bit entry {ch_id, opcode, addr, wbuffer_id} in a DEPTH-entry circular buffer.
REQ-016 Enqueue SHALL occur on a cycle where xbar_htu_valid_i && xbar_htu_ready_o; dequeue where htu_req_valid_o && htu_req_ready_i.
REQ-017 xbar_htu_ready_o SHALL be 1 iff occupancy < DEPTH (registered-state derived; no combinational path from htu_req_ready_i).
REQ-018 htu_req_valid_o SHALL be 1 iff occupancy > 0; output fields SHALL equal the head entry, stable while valid and not ready.
REQ-019 Write and read pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-020 Occupancy: +1 on enqueue only, -1 on dequeue only, unchanged on simultaneous enqueue+dequeue or neither.
REQ-021 When full, simultaneous dequeue SHALL NOT enable enqueue in the same cycle (ready stays 0); enqueue possible next cycle.
REQ-022 When empty, an enqueued entry SHALL appear on htu_req_valid_o the following cycle (latency 1) unless bypass is enabled (REQ-026).
REQ-023 Entries SHALL leave in strict arrival order; no entry lost or duplicated.
REQ-024 Input fields when xbar_htu_valid_i=0 SHALL be ignored.

Reset
REQ-025 On rst_i=0, immediately and asynchronously: pointers=0, occupancy=0, htu_req_valid_o=0, xbar_htu_ready_o=1 after release, htu_req_cnt_o=0; entry storage need not be cleared; reset mid-operation discards all queued entries.

Configuration
REQ-026 With HTU_REQQ_BYPASS_EN defined: when queue empty and xbar_htu_valid_i=1, htu_req_valid_o=1 and fields pass combinationally from inputs; if htu_req_ready_i=1 that cycle, request is consumed without being written (occupancy unchanged); otherwise it is enqueued normally.
REQ-027 Without HTU_REQQ_BYPASS_EN: no combinational input-to-output path; minimum latency 1 cycle per REQ-022.

Verification
REQ-028 Reset then single request ch_id=1, op=2, addr=0x1234567, wbuf_id=0x5A, htu_req_ready_i=1 -> valid_o next cycle with identical fields, cnt returns 0 (same cycle valid with bypass).
REQ-029 htu_req_ready_i=0, push 4 requests -> cnt=4, xbar_htu_ready_o=0; 5th held by source; release ready -> 4 entries out in order, then 5th.
REQ-030 Occupancy 2, simultaneous enqueue+dequeue for 10 cycles -> cnt stays 2, order preserved across pointer wrap.
REQ-031 Full queue, htu_req_ready_i=1 -> xbar_htu_ready_o=0 that cycle, 1 next cycle; cnt 4->3.
REQ-032 Assert rst_i=0 with cnt=3 mid-stream -> valid_o=0, cnt=0 immediately; after release, next push exits with correct fields, no stale entries.
REQ-033 Random valid/ready (50% each), 1000 requests -> scoreboard matches all fields in order, cnt never exceeds 4.
